spw_rx_drain: RTL and testbench
===============================

SPW_RX_DRAIN -- requirements
Module: spw_rx_drain

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, local buffer depth in 9-bit words, power of two, range 4..256.
REQ-002 SHALL have parameter CNT_W, default 16, width of the packet counters.
REQ-003 SHALL have port CLOCK, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port RESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ENABLE, input, 1 bit: permits new reads from the link receive FIFO.
REQ-006 SHALL have port FLUSH, input, 1 bit: synchronous clear of the local buffer.
REQ-007 SHALL have port DATA_O, input, 9 bits: receive character from SPW_TOP; bit 8 = control flag.
REQ-008 SHALL have port RX_EMPTY, input, 1 bit: SPW_TOP receive FIFO empty.
REQ-009 SHALL have port RD_DATA, output, 1 bit: read strobe to SPW_TOP.
REQ-010 SHALL have port RX_DATA, output, 9 bits: head word of the local buffer.
REQ-011 SHALL have port RX_VALID, output, 1 bit: RX_DATA holds a valid word.
REQ-012 SHALL have port RX_READY, input, 1 bit: consumer accepts the word.
REQ-013 SHALL have port LEVEL, output, $clog2(FIFO_DEPTH)+1 bits: buffer occupancy.
REQ-014 SHALL have port PKT_COUNT, output, CNT_W bits: EOP characters captured.
REQ-015 SHALL have port EEP_COUNT, output, CNT_W bits: EEP characters captured.

Function
REQ-016 SHALL run the read FSM over states IDLE, REQ and CAPT.
REQ-017 SHALL go IDLE->REQ when ENABLE=1, RX_EMPTY=0, FLUSH=0 and LEVEL<FIFO_DEPTH.
REQ-018 SHALL drive RD_DATA=1 registered in REQ only (one-cycle pulse), then go REQ->CAPT.
REQ-019 SHALL sample DATA_O in CAPT (one-cycle read latency), write it to the buffer and go CAPT->IDLE; peak rate is one word per 3 cycles.
REQ-020 SHALL count the CAPT slot as occupied in the LEVEL<FIFO_DEPTH check, so the buffer never overflows.
REQ-021 SHALL present the buffer first-word-fall-through: RX_VALID=(LEVEL!=0), RX_DATA=head, and pop on RX_VALID&RX_READY.
REQ-022 SHALL, on a simultaneous push (CAPT) and pop, leave LEVEL unchanged and keep the data order correct, including at LEVEL=FIFO_DEPTH-1 and at LEVEL=1.
REQ-023 SHALL increment PKT_COUNT when a captured word equals 9'h100 (EOP) and EEP_COUNT when it equals 9'h101 (EEP), wrapping modulo 2^CNT_W.
REQ-024 SHALL, when ENABLE falls, finish any word in REQ/CAPT, then hold IDLE.
REQ-025 SHALL, on FLUSH=1, empty the buffer (LEVEL=0, RX_VALID=0 next cycle), discard any word in CAPT, return to IDLE, and leave the counters unchanged.
REQ-026 SHALL NOT issue RD_DATA while FLUSH=1.

Reset
REQ-027 SHALL, on RESETn=0 (asynchronous), force FSM=IDLE, RD_DATA=0, LEVEL=0, RX_VALID=0, RX_DATA=0, PKT_COUNT=0 and EEP_COUNT=0.
REQ-028 SHALL, on reset during REQ/CAPT, drop the in-flight word without writing it.
REQ-029 SHALL release reset with the synchronous logic first active on the first CLOCK edge after RESETn rises.

Configuration
REQ-030 SHALL, with macro SPW_RX_DRAIN_PKT_STATS_EN defined, implement PKT_COUNT and EEP_COUNT per REQ-023.
REQ-031 SHALL, without SPW_RX_DRAIN_PKT_STATS_EN, keep both ports and tie them to 0, with no counter flops present.

Structure
REQ-032 SHALL place in shared package spw_pkg: the constants SPW_EOP=9'h100 and SPW_EEP=9'h101, and the FSM state enum typedef.
REQ-033 SHALL implement the buffer as sub-module spw_sync_fifo (FWFT, parameterised width and depth, with LEVEL output).

Verification
REQ-034 Reset: assert RESETn=0 mid-CAPT -> RD_DATA=0, LEVEL=0, counters=0, and no word appears after release.
REQ-035 Single word: DATA_O=9'h041, RX_EMPTY=0 for one read -> RD_DATA pulses once, and RX_VALID=1 with RX_DATA=9'h041 three cycles later.
REQ-036 Full: RX_READY=0 with 20 words available and FIFO_DEPTH=16 -> exactly 16 RD_DATA pulses and LEVEL=16; then RX_READY=1 -> all 20 words out in order.
REQ-037 Packets: stream 5 data words+9'h100, 3 data words+9'h101, 2 data words+9'h100 -> PKT_COUNT=2, EEP_COUNT=1 (0/0 without the macro).
REQ-038 Flush: LEVEL=7 with a word in CAPT, FLUSH=1 for 1 cycle -> LEVEL=0, RX_VALID=0, counters unchanged, and reads resume next IDLE.
REQ-039 Wrap/simultaneous: CNT_W=4 with 17 EOPs -> PKT_COUNT=1; continuous RX_READY=1 at LEVEL=1 during push -> LEVEL stays 1.

Source files
------------

// File: rtl/spw_pkg.sv
// spw_pkg: shared SpaceWire character codes and the receive-drain read FSM states.
package spw_pkg;
    localparam logic [8:0] SPW_EOP = 9'h100;
    localparam logic [8:0] SPW_EEP = 9'h101;
    typedef enum logic [1:0] {IDLE, REQ, CAPT} spw_rd_state_e;
endpackage

// File: rtl/spw_rx_drain_if.sv
// spw_rx_drain_if: FWFT consumer stream (head word, valid/ready, occupancy).
interface spw_rx_drain_if #(
    parameter int W  = 9,
    parameter int LW = 5
);
    logic [W-1:0]  data;
    logic          valid;
    logic          ready;
    logic [LW-1:0] level;
    modport master (output data, valid, level, input ready);
    modport slave  (input data, valid, level, output ready);
endinterface

// File: rtl/spw_sync_fifo.sv
// spw_sync_fifo: first-word-fall-through synchronous FIFO with occupancy output.
module spw_sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clr_i,
    input  logic           push_i,
    input  logic [W-1:0]   wdata_i,
    spw_rx_drain_if.master rd_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop, wr;
    assign pop        = rd_o.valid && rd_o.ready;
    assign wr         = push_i && !clr_i && (cnt_q != CW'(DEPTH) || pop);
    assign rd_o.valid = cnt_q != '0;
    assign rd_o.data  = rd_o.valid ? mem_q[rd_q] : '0;
    assign rd_o.level = cnt_q;
    always_comb begin
        wr_d  = clr_i ? '0 : wr_q + AW'(wr);
        rd_d  = clr_i ? '0 : rd_q + AW'(pop);
        cnt_d = clr_i ? '0 : cnt_q + CW'(wr) - CW'(pop);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/spw_rx_drain.sv
// spw_rx_drain: drains the SpaceWire receive FIFO into a local FWFT buffer.
// EOP/EEP counters exist only with SPW_RX_DRAIN_PKT_STATS_EN defined; otherwise they read 0.
module spw_rx_drain
    import spw_pkg::*;
#(
    parameter int  FIFO_DEPTH = 16,
    parameter int  CNT_W      = 16,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             CLOCK,
    input  logic             RESETn,
    input  logic             ENABLE,
    input  logic             FLUSH,
    input  logic [8:0]       DATA_O,
    input  logic             RX_EMPTY,
    output logic             RD_DATA,
    output logic [8:0]       RX_DATA,
    output logic             RX_VALID,
    input  logic             RX_READY,
    output logic [LW-1:0]    LEVEL,
    output logic [CNT_W-1:0] PKT_COUNT,
    output logic [CNT_W-1:0] EEP_COUNT
);
    spw_rd_state_e state_q, state_d;
    logic          start, push;
    spw_rx_drain_if #(.W(9), .LW(LW)) buf_if ();
    // At most one word is in flight and it lands before IDLE is re-entered,
    // so the LEVEL check made from IDLE already covers the CAPT slot.
    assign start   = ENABLE && !RX_EMPTY && !FLUSH && LEVEL < LW'(FIFO_DEPTH);
    assign push    = state_q == CAPT && !FLUSH;
    assign RD_DATA = state_q == REQ && !FLUSH;
    always_comb begin
        state_d = state_q == IDLE ? (start ? REQ : IDLE)
                : state_q == REQ  ? (FLUSH ? IDLE : CAPT)
                : IDLE;
    end
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) state_q <= IDLE;
        else         state_q <= state_d;
    end
    spw_sync_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (CLOCK),
        .rst_ni  (RESETn),
        .clr_i   (FLUSH),
        .push_i  (push),
        .wdata_i (DATA_O),
        .rd_o    (buf_if)
    );
    assign RX_DATA      = buf_if.data;
    assign RX_VALID     = buf_if.valid;
    assign LEVEL        = buf_if.level;
    assign buf_if.ready = RX_READY;
`ifdef SPW_RX_DRAIN_PKT_STATS_EN
    logic [CNT_W-1:0] pkt_q, pkt_d, eep_q, eep_d;
    always_comb begin
        pkt_d = pkt_q + CNT_W'(push && DATA_O == SPW_EOP);
        eep_d = eep_q + CNT_W'(push && DATA_O == SPW_EEP);
    end
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            pkt_q <= '0;
            eep_q <= '0;
        end else begin
            pkt_q <= pkt_d;
            eep_q <= eep_d;
        end
    end
    assign PKT_COUNT = pkt_q;
    assign EEP_COUNT = eep_q;
`else
    assign PKT_COUNT = '0;
    assign EEP_COUNT = '0;
`endif
endmodule

// File: tb/tb_spw_rx_drain.sv
// tb_spw_rx_drain: vector table, corner sequences and randomized traffic against a queue model.
module tb_spw_rx_drain;
    import spw_pkg::*;
    localparam int DEPTH = 16;
    localparam int CW    = 4;
`ifdef SPW_RX_DRAIN_PKT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic          CLOCK = 1'b0, RESETn = 1'b1, ENABLE = 1'b0, FLUSH = 1'b0, RX_READY = 1'b0;
    logic          RX_EMPTY, RD_DATA, RX_VALID;
    logic [8:0]    DATA_O = '0;
    logic [8:0]    RX_DATA;
    logic [4:0]    LEVEL;
    logic [CW-1:0] PKT_COUNT, EEP_COUNT;

    spw_rx_drain_if #(.W(9), .LW(5)) rx_if ();
    assign rx_if.data  = RX_DATA;
    assign rx_if.valid = RX_VALID;
    assign rx_if.level = LEVEL;
    assign rx_if.ready = RX_READY;

    always #5 CLOCK = ~CLOCK;

    spw_rx_drain #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .CLOCK(CLOCK), .RESETn(RESETn), .ENABLE(ENABLE), .FLUSH(FLUSH),
        .DATA_O(DATA_O), .RX_EMPTY(RX_EMPTY), .RD_DATA(RD_DATA),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .LEVEL(LEVEL), .PKT_COUNT(PKT_COUNT), .EEP_COUNT(EEP_COUNT)
    );

    // link-side receive FIFO with one-cycle read latency
    logic [8:0]  link_mem [0:4095];
    int unsigned wr_n = 0, rd_n = 0, rd_pulses = 0;
    assign RX_EMPTY = rd_n >= wr_n;
    always @(posedge CLOCK) begin
        if (RD_DATA) begin
            DATA_O    <= link_mem[12'(rd_n)];
            rd_n      <= rd_n + 1;
            rd_pulses <= rd_pulses + 1;
        end
    end

    logic [8:0]  got [$];
    int unsigned viol = 0;
    always @(posedge CLOCK) begin
        if (rx_if.valid && rx_if.ready) got.push_back(rx_if.data);
        if (RESETn && ((RX_VALID != (LEVEL != 0)) || LEVEL > 5'(DEPTH) || (RD_DATA && FLUSH))) viol <= viol + 1;
    end

    int         n_tests = 0, n_fail = 0;
    int         mark = 0, exp_pkt = 0, exp_eep = 0;
    logic [8:0] exp_q [$];

    typedef struct {
        logic [8:0] din;
        logic [8:0] dout;
        int         pkt;
        int         eep;
    } vec_t;
    vec_t tv [6];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic send(input logic [8:0] w, input bit keep);
        link_mem[12'(wr_n)] = w;
        wr_n++;
        if (keep) begin
            exp_q.push_back(w);
            if (w == SPW_EOP) exp_pkt++;
            if (w == SPW_EEP) exp_eep++;
        end
    endtask

    task automatic check_cnt(input string name);
        check({name, "_pkt"}, int'(PKT_COUNT), STATS ? exp_pkt % 16 : 0);
        check({name, "_eep"}, int'(EEP_COUNT), STATS ? exp_eep % 16 : 0);
    endtask

    task automatic wait_level(input int lvl, input string name);
        for (int i = 0; i < 200 && int'(LEVEL) != lvl; i++) tick();
        check(name, int'(LEVEL), lvl);
    endtask

    task automatic drain_check(input string name);
        int bad = 0;
        for (int k = 0; k < 2000 && got.size() - mark < exp_q.size(); k++) tick();
        check({name, "_count"}, got.size() - mark, exp_q.size());
        for (int i = 0; i < exp_q.size() && mark + i < got.size(); i++)
            if (got[mark + i] != exp_q[i]) bad++;
        check({name, "_order"}, bad, 0);
        mark = got.size();
        exp_q.delete();
    endtask

    // push lands on the same edge as a pop: LEVEL must not move
    task automatic simul(input logic [8:0] w, input int lvl, input string name);
        send(w, 1'b1);
        tick(2);
        RX_READY = 1'b1;
        tick();
        RX_READY = 1'b0;
        check({name, "_level"}, int'(LEVEL), lvl);
        check({name, "_head"}, int'(RX_DATA), int'(exp_q[got.size() - mark]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned p0;
        int          lat;
        logic [8:0]  w;
        int unsigned r;
        int          sent;
        tv[0] = '{9'h041, 9'h041, 0, 0};
        tv[1] = '{9'h100, 9'h100, 1, 0};
        tv[2] = '{9'h1FF, 9'h1FF, 1, 0};
        tv[3] = '{9'h101, 9'h101, 1, 1};
        tv[4] = '{9'h000, 9'h000, 1, 1};
        tv[5] = '{9'h100, 9'h100, 2, 1};

        #1 RESETn = 1'b0;
        tick(3);
        check("rst_level", int'(LEVEL), 0);
        check("rst_valid", int'(RX_VALID), 0);
        check("rst_data", int'(RX_DATA), 0);
        check("rst_rd", int'(RD_DATA), 0);
        check("rst_pkt", int'(PKT_COUNT), 0);
        check("rst_eep", int'(EEP_COUNT), 0);
        RESETn = 1'b1;
        ENABLE = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            p0 = rd_pulses;
            send(tv[i].din, 1'b1);
            for (lat = 1; lat <= 20; lat++) begin
                tick();
                if (RX_VALID) break;
            end
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_rd_pulses", i), int'(rd_pulses - p0), 1);
            check($sformatf("vec%0d_data", i), int'(RX_DATA), int'(tv[i].dout));
            check($sformatf("vec%0d_pkt", i), int'(PKT_COUNT), STATS ? tv[i].pkt : 0);
            check($sformatf("vec%0d_eep", i), int'(EEP_COUNT), STATS ? tv[i].eep : 0);
            RX_READY = 1'b1;
            tick();
            RX_READY = 1'b0;
        end
        drain_check("vec");

        p0 = rd_pulses;
        for (int i = 0; i < 20; i++) send(9'(16 + i), 1'b1);
        tick(80);
        check("full_rd_pulses", int'(rd_pulses - p0), 16);
        check("full_level", int'(LEVEL), 16);
        check("full_valid", int'(RX_VALID), 1);
        RX_READY = 1'b1;
        drain_check("full");
        check("full_rd_total", int'(rd_pulses - p0), 20);
        RX_READY = 1'b0;

        send(9'h0A1, 1'b1);
        wait_level(1, "l1_fill");
        simul(9'h0A2, 1, "l1");
        RX_READY = 1'b1;
        drain_check("l1");
        RX_READY = 1'b0;

        for (int i = 0; i < 15; i++) send(9'(9'h0C0 + i), 1'b1);
        wait_level(15, "l15_fill");
        simul(9'h0B0, 15, "l15");
        RX_READY = 1'b1;
        drain_check("l15");
        RX_READY = 1'b0;

        for (int i = 0; i < 7; i++) send(9'(9'h060 + i), 1'b1);
        wait_level(7, "flush_fill");
        send(SPW_EOP, 1'b0);
        tick(2);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("flush_level", int'(LEVEL), 0);
        check("flush_valid", int'(RX_VALID), 0);
        check_cnt("flush");
        exp_q.delete();
        mark = got.size();
        send(9'h055, 1'b1);
        RX_READY = 1'b1;
        drain_check("flush_resume");

        for (int i = 0; i < 5; i++) send(9'(9'h020 + i), 1'b1);
        send(SPW_EOP, 1'b1);
        for (int i = 0; i < 3; i++) send(9'(9'h030 + i), 1'b1);
        send(SPW_EEP, 1'b1);
        for (int i = 0; i < 2; i++) send(9'(9'h040 + i), 1'b1);
        send(SPW_EOP, 1'b1);
        drain_check("pkt");
        check_cnt("pkt");

        sent = 0;
        for (int c = 0; c < 3000 && sent < 60; c++) begin
            RX_READY = 1'($urandom);
            ENABLE   = ($urandom % 8) != 0;
            if ($urandom % 3 == 0) begin
                r = $urandom % 8;
                w = r == 0 ? SPW_EOP : r == 1 ? SPW_EEP : 9'($urandom % 256);
                send(w, 1'b1);
                sent++;
            end
            tick();
        end
        ENABLE   = 1'b1;
        RX_READY = 1'b1;
        drain_check("rand");
        check_cnt("rand");

        RX_READY = 1'b0;
        send(9'h011, 1'b1);
        send(9'h012, 1'b1);
        wait_level(2, "rstcapt_fill");
        send(SPW_EOP, 1'b0);
        tick(2);
        RESETn = 1'b0;
        #1;
        check("rstcapt_rd", int'(RD_DATA), 0);
        check("rstcapt_level", int'(LEVEL), 0);
        check("rstcapt_valid", int'(RX_VALID), 0);
        check("rstcapt_pkt", int'(PKT_COUNT), 0);
        check("rstcapt_eep", int'(EEP_COUNT), 0);
        exp_q.delete();
        exp_pkt = 0;
        exp_eep = 0;
        mark = got.size();
        tick(2);
        RESETn = 1'b1;
        p0 = rd_pulses;
        tick(10);
        check("rstcapt_after_valid", int'(RX_VALID), 0);
        check("rstcapt_after_level", int'(LEVEL), 0);
        check("rstcapt_after_rd", int'(rd_pulses - p0), 0);

        RX_READY = 1'b1;
        for (int i = 0; i < 17; i++) send(SPW_EOP, 1'b1);
        drain_check("wrap");
        check("wrap_pkt", int'(PKT_COUNT), STATS ? 1 : 0);
        check("wrap_eep", int'(EEP_COUNT), 0);

        check("invariants", int'(viol), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
